// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared types and defaults for the PRNG stream controller
package prng_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_REP_LIMIT = 4;
    localparam int RESEED_CNT_W  = 8;

endpackage

// File: rtl/prng_fifo.sv
// rtl/prng_fifo.sv - synchronous FIFO with flush, head data and occupancy count
module prng_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Empty FIFO presents zero rather than stale storage.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/prng_stream.sv
// rtl/prng_stream.sv - PRNG bank controller with repetition health test and output stream
module prng_stream
    import prng_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [WIDTH-1:0]        seed_base,
    input  logic [WIDTH-1:0]        rand_in,
    output logic                    update,
    output logic                    reseed,
    output logic [WIDTH-1:0]        seed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    health_err,
    output logic [RESEED_CNT_W-1:0] reseed_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(REP_LIMIT + 1);

    state_t           state_q;
    state_t           state_d;
    logic             upd_q;
    logic             fresh_q;
    logic [RW-1:0]    rep_cnt;
    logic [RW-1:0]    rep_next;
    logic [WIDTH-1:0] last_word;
    logic [WIDTH-1:0] cnt_w;
    logic [AW:0]      count;
    logic [AW+1:0]    reserved;
    logic             fail;
    logic             push;
    logic             pop;

    always_comb begin
        cnt_w = '0;
        for (int i = 0; i < WIDTH && i < RESEED_CNT_W; i++) cnt_w[i] = reseed_cnt[i];
    end

    always_comb begin
        rep_next = RW'(1);
        if (!fresh_q && rand_in == last_word) rep_next = rep_cnt + 1'b1;
    end

    assign fail     = upd_q && (rep_next >= RW'(REP_LIMIT));
    assign push     = upd_q && !fail;
    assign pop      = out_valid && out_ready;
    // Occupancy plus the word already requested from the bank.
    assign reserved = {1'b0, count} + {{(AW + 1){1'b0}}, upd_q};

    always_comb begin
        state_d = state_q;
        update  = 1'b0;
        reseed  = 1'b0;
        seed    = '0;
        case (state_q)
            SEED: begin
                reseed  = !rst;
                seed    = rst ? '0 : (seed_base ^ cnt_w);
                state_d = SETTLE;
            end
            SETTLE:  state_d = RUN;
            RUN:     update = !rst && en && (reserved < (AW + 2)'(DEPTH));
            default: state_d = SEED;
        endcase
        if (fail) state_d = SEED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEED;
            upd_q      <= 1'b0;
            fresh_q    <= 1'b1;
            rep_cnt    <= '0;
            last_word  <= '0;
            health_err <= 1'b0;
            reseed_cnt <= '0;
        end else begin
            state_q    <= state_d;
            health_err <= fail;
            upd_q      <= update && !fail;
            if (state_q == SEED) fresh_q <= 1'b1;
            if (upd_q) begin
                fresh_q <= 1'b0;
                rep_cnt <= rep_next;
                if (!fail) last_word <= rand_in;
            end
            if (fail && reseed_cnt != {RESEED_CNT_W{1'b1}}) reseed_cnt <= reseed_cnt + 1'b1;
        end
    end

    prng_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (fail),
        .wdata (rand_in),
        .head  (out_data),
        .count (count)
    );

    assign out_valid = (count != '0);

endmodule

// File: tb/tb_prng_stream.sv
// tb/tb_prng_stream.sv - scoreboard bench for prng_stream with stub PRNG bank
module tb_prng_stream;
    import prng_pkg::*;

    localparam int DEPTH     = 4;
    localparam int REP_LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] seed_base = 8'h5A;
    logic [7:0] rand_in = 8'h00;
    logic       update, reseed, out_valid, health_err;
    logic [7:0] seed, out_data, reseed_cnt;

    int checks = 0;
    int errors = 0;

    int         mode = 0;
    logic [7:0] ctr = 8'h00;

    logic [7:0] exp_q[$];
    logic [7:0] hist[$];
    bit         pending = 0;
    bit         herr_exp = 0;
    bit         reseed_exp = 0;
    bit         started = 0;
    int         exp_cnt = 0;

    prng_stream dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seed_base  (seed_base),
        .rand_in    (rand_in),
        .update     (update),
        .reseed     (reseed),
        .seed       (seed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .health_err (health_err),
        .reseed_cnt (reseed_cnt)
    );

    always #5 clk = ~clk;

    // Registered stub bank: word requested in cycle t appears in cycle t+1.
    always @(posedge clk) begin
        if (update) begin
            case (mode)
                0: begin
                    ctr     <= ctr + 8'd1;
                    rand_in <= ctr + 8'd1;
                end
                1:       rand_in <= 8'hA7;
                default: rand_in <= 8'h30 + 8'($urandom_range(0, 3));
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor then reference model, once per cycle away from the clock edge.
    always @(negedge clk) begin : model
        int run;
        bit fail;
        if (started) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
            chk("health_err", health_err, herr_exp);
            chk("reseed", reseed, reseed_exp && !rst);
            chk("reseed_cnt", reseed_cnt, exp_cnt);
            if (reseed) chk("seed", seed, seed_base ^ exp_cnt[7:0]);
            chk("update_rule", update && (!en || exp_q.size() + int'(pending) >= DEPTH), 0);
            chk("update_reseed_excl", update && reseed, 0);
            chk("push_when_full", dut.push && (dut.count == DEPTH), 0);
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (rst) begin
            started    = 1;
            exp_q.delete();
            hist.delete();
            pending    = 0;
            herr_exp   = 0;
            reseed_exp = 1;
            exp_cnt    = 0;
        end else begin
            fail = 0;
            if (pending) begin
                hist.push_back(rand_in);
                run = 0;
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i] != rand_in) break;
                    run++;
                end
                if (hist.size() > REP_LIMIT) void'(hist.pop_front());
                if (run >= REP_LIMIT) begin
                    fail = 1;
                    exp_q.delete();
                    hist.delete();
                    if (exp_cnt < 255) exp_cnt++;
                end else begin
                    exp_q.push_back(rand_in);
                end
            end
            herr_exp   = fail;
            reseed_exp = fail;
            pending    = update && !fail;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        int maxc;
        int herr_total;

        // Reset values, then fill with a stalled consumer.
        rst = 1; en = 1; out_ready = 0; mode = 0;
        tick; tick;
        @(negedge clk);
        chk("rst_update", update, 0);
        chk("rst_reseed", reseed, 0);
        chk("rst_seed", seed, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_health_err", health_err, 0);
        chk("rst_reseed_cnt", reseed_cnt, 0);
        tick; rst = 0;
        repeat (20) tick;
        @(negedge clk);
        chk("fill_count", dut.count, DEPTH);
        chk("fill_update", update, 0);
        chk("fill_head", out_data, 8'h01);
        tick; out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, i);
            tick;
        end

        // Start-up timing after reset release.
        rst = 1; tick; rst = 0;
        @(negedge clk);
        chk("c1_reseed", reseed, 1);
        chk("c1_seed", seed, 8'h5A);
        chk("c1_update", update, 0);
        tick; @(negedge clk);
        chk("c2_reseed", reseed, 0);
        chk("c2_update", update, 0);
        tick; @(negedge clk);
        chk("c3_update", update, 1);
        tick; @(negedge clk);
        chk("c4_out_valid", out_valid, 0);
        tick; @(negedge clk);
        chk("c5_out_valid", out_valid, 1);
        tick;

        // en dropped with a word in flight.
        mode = 2;
        guard = 0;
        while (!update && guard < 50) begin tick; guard++; end
        chk("wait_update_timeout", guard < 50, 1);
        tick; en = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en_low_update", update, 0);
            tick;
        end
        chk("en_low_drained", out_valid, 0);
        en = 1;

        // Stuck bank: first health failure.
        rst = 1; mode = 1; out_ready = 0; tick; rst = 0;
        guard = 0; maxc = 0;
        while (guard < 40) begin
            @(negedge clk);
            if (int'(dut.count) > maxc) maxc = int'(dut.count);
            if (health_err) break;
            guard++;
        end
        chk("stuck_timeout", guard < 40, 1);
        chk("stuck_max_fill", maxc, 3);
        chk("stuck_reseed_cnt", reseed_cnt, 1);
        chk("stuck_flushed", out_valid, 0);
        chk("stuck_reseed", reseed, 1);
        chk("stuck_seed", seed, 8'h5B);
        tick;

        // Repeated failures until the reseed counter saturates.
        out_ready = 1;
        herr_total = 1; guard = 0;
        while (herr_total < 300 && guard < 6000) begin
            tick;
            if (health_err) herr_total++;
            guard++;
        end
        chk("saturate_timeout", guard < 6000, 1);
        @(negedge clk);
        chk("saturate_cnt", reseed_cnt, 255);
        tick;

        // Reset with count=3 and a word in flight.
        mode = 0; out_ready = 0; rst = 1; tick; rst = 0;
        guard = 0;
        while (!(dut.count == 3 && dut.upd_q) && guard < 30) begin tick; guard++; end
        chk("midrst_timeout", guard < 30, 1);
        rst = 1; tick; rst = 0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_count", dut.count, 0);
        chk("midrst_state", dut.state_q, SEED);
        chk("midrst_reseed", reseed, 1);
        tick;
        out_ready = 1;
        repeat (30) tick;

        // Random traffic against the scoreboard.
        mode = 2;
        for (int i = 0; i < 800; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            out_ready = $urandom_range(0, 1);
            tick;
        end
        en = 0; out_ready = 1;
        repeat (10) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prng_stream.md
Name: prng_stream

Overview:
- Downstream consumer and controller for the parallel PRNG bank.
- Owns the bank's update/reseed/seed inputs and captures its rand word after each update.
- Runs a repetition-count health test on captured words; a stuck value triggers a flush and an automatic reseed.
- Buffers good words in a small FIFO and presents them as a valid/ready stream to downstream logic.

Parameters:
- WIDTH, 8, word width; equals the PRNG bank width.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- REP_LIMIT, 4, number of identical consecutive captured words that counts as a health failure; minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable word generation; when low, no new updates issue.
- seed_base  in  WIDTH  base seed; sampled only in SEED state.
- rand_in  in  WIDTH  rand output of the PRNG bank.
- update  out  1  update strobe to the PRNG bank.
- reseed  out  1  reseed strobe to the PRNG bank.
- seed  out  WIDTH  seed to the PRNG bank.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH  FIFO head word.
- health_err  out  1  single-cycle pulse on each health failure.
- reseed_cnt  out  8  number of reseeds since reset; saturates at 255.

Behaviour:
- Reset values: update=0, reseed=0, seed=0, out_valid=0, out_data=0, health_err=0, reseed_cnt=0. FIFO empty, rep_cnt=0, upd_q=0, FSM in SEED.
- Reset asserted mid-operation discards all FIFO contents and any pending capture on the next edge.
- The PRNG bank is registered: a word requested by update in cycle t is valid on rand_in in cycle t+1.
- FSM states:
  - SEED: for exactly 1 cycle, drive reseed=1 and seed = seed_base XOR reseed_cnt[WIDTH-1:0], zero-extended if WIDTH>8. Next state is SETTLE.
  - SETTLE: 1 cycle; update=0, no capture. Next state is RUN.
  - RUN: update = en AND (count + upd_q < DEPTH). Space for the in-flight word is reserved.
- Capture:
  - upd_q is update delayed by one cycle.
  - When upd_q=1, rand_in is captured and compared with last_word.
  - rep_cnt: reset to 1 on the first capture after SEED; on each later capture, incremented if the word equals last_word, otherwise set to 1.
- Good capture (rep_cnt after capture < REP_LIMIT): the word is pushed into the FIFO and last_word is updated.
- Health failure (rep_cnt reaches REP_LIMIT):
  - Pulse health_err for 1 cycle.
  - Do not push the failing word; flush the FIFO (count=0, out_valid=0 next cycle).
  - Increment reseed_cnt (saturating), clear upd_q, go to SEED.
  - Flush takes priority over a simultaneous pop.
- FIFO:
  - Push and pop in the same cycle are both legal; count is unchanged.
  - A pop occurs when out_valid AND out_ready.
  - out_valid = (count != 0). out_data is the head entry, registered storage with no combinational path from rand_in.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Push when full cannot occur because of the space reservation; the bench asserts this.
- Stream rule: once out_valid is high, out_data is held stable until accepted, except on flush or rst.
- en deassert: no further update. An in-flight word (upd_q=1) is still captured.
- update and reseed are never high in the same cycle.
- Latency: a word requested by update in cycle t is visible on out_data in cycle t+2 when the FIFO was empty.

Decomposition:
- Shared package prng_pkg:
  - FSM state enum (SEED, SETTLE, RUN).
  - Default constants for WIDTH, DEPTH, REP_LIMIT.
  - Reseed counter width (8).
- One sub-module: prng_fifo, a synchronous FIFO parameterised by WIDTH and DEPTH, with push, pop, flush, count, and head data.
- FSM, capture, and health logic stay in prng_stream.

Test Plan:
1. Reset, then seed_base=8'h5A, en=1 -> reseed=1 with seed=8'h5A in cycle 1 after rst falls; update=0 in cycle 2 (SETTLE); update=1 from cycle 3; first out_valid in cycle 5.
2. DEPTH=4, out_ready=0, with a stub bank returning incrementing words 01,02,03... -> exactly 4 words captured, count=4, update=0 thereafter. Then out_ready=1 -> out_data reads 01,02,03,04 in order, with continuous flow at one word per cycle.
3. Stub bank returns 8'hA7 constantly, REP_LIMIT=4 -> three words of A7 pushed; on the 4th capture health_err pulses, FIFO flushes, reseed_cnt=1; next SEED drives seed=8'h5A^8'h01=8'h5B.
4. Repeated failures (stub stuck) for 300 reseeds -> reseed_cnt saturates at 255; seed on each reseed = seed_base XOR reseed_cnt.
5. en dropped in the same cycle update=1 -> that word is still captured and pushed; no further update until en returns.
6. rst asserted with count=3 and upd_q=1 -> next cycle out_valid=0, count=0, FSM in SEED, and the in-flight word is never output.
